// File: rtl/synth_voice_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | synth_voice_sequencer: per-sample key scan driving the synth data_path.     |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module synth_voice_sequencer #(
   parameter int NUM_KEYS = 128
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SAMPLE_REQ,
   input  logic        LD_VEL,
   input  logic [6:0]  AVL_KEY,
   input  logic [6:0]  AVL_VEL,
   input  logic        NOTE_END,
   input  logic        ATT_OFF,
   input  logic [31:0] TONE,
   output logic [6:0]  KEY,
   output logic        LD_PHASE,
   output logic        LD_AMP,
   output logic        LD_TONE,
   output logic        PHASE_MUX,
   output logic        TONE_MUX,
   output logic        AMP_SEL,
   output logic        NOTE_ON,
   output logic        ATT_ON,
   output logic [23:0] SAMPLE_OUT,
   output logic        SAMPLE_VALID,
   output logic        BUSY,
   output logic        OVERRUN
);

   localparam logic [6:0] LAST_KEY = 7'(NUM_KEYS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [6:0]          key_q, key_d;
   logic [NUM_KEYS-1:0] held_q, held_d;
   logic [NUM_KEYS-1:0] att_q, att_d;
   logic [NUM_KEYS-1:0] active_q, active_d;
   logic [NUM_KEYS-1:0] restart_q, restart_d;
   logic [23:0]         sample_out_q, sample_out_d;
   logic                sample_valid_q, sample_valid_d;
   logic                overrun_q, overrun_d;

   logic cur_held, cur_att, cur_active, cur_restart, scan_hit;
   logic unused_tone_lsbs;

   assign cur_held    = held_q[key_q];
   assign cur_att     = att_q[key_q];
   assign cur_active  = active_q[key_q];
   assign cur_restart = restart_q[key_q];
   assign scan_hit    = (state_q == ST_SCAN) && cur_active;

   // Only the upper 24 bits of the accumulator reach the audio output.
   assign unused_tone_lsbs = ^TONE[7:0];

   assign KEY          = key_q;
   assign SAMPLE_OUT   = sample_out_q;
   assign SAMPLE_VALID = sample_valid_q;
   assign OVERRUN      = overrun_q;
   assign BUSY         = (state_q != ST_IDLE);

   // Strobes depend only on registered state, so they are stable all cycle.
   always_comb begin
      LD_PHASE  = 1'b0;
      LD_AMP    = 1'b0;
      LD_TONE   = 1'b0;
      PHASE_MUX = 1'b0;
      TONE_MUX  = 1'b0;
      AMP_SEL   = 1'b0;
      NOTE_ON   = 1'b0;
      ATT_ON    = 1'b0;
      if (state_q == ST_CLEAR) begin
         LD_TONE = 1'b1;
      end else if (scan_hit) begin
         LD_PHASE  = 1'b1;
         LD_AMP    = 1'b1;
         LD_TONE   = 1'b1;
         TONE_MUX  = 1'b1;
         PHASE_MUX = ~cur_restart;
         AMP_SEL   = cur_restart;
         ATT_ON    = cur_restart | cur_att;
         NOTE_ON   = cur_held;
      end
   end

   always_comb begin
      state_d        = state_q;
      key_d          = key_q;
      held_d         = held_q;
      att_d          = att_q;
      active_d       = active_q;
      restart_d      = restart_q;
      sample_out_d   = sample_out_q;
      sample_valid_d = 1'b0;
      overrun_d      = overrun_q | (SAMPLE_REQ && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            key_d = 7'd0;
            if (SAMPLE_REQ) begin
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            key_d   = 7'd0;
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            key_d = key_q + 7'd1;
            if (key_q == LAST_KEY) begin
               state_d = ST_DONE;
            end
            if (cur_active) begin
               if (cur_restart) begin
                  restart_d[key_q] = 1'b0;
               end else begin
                  if (ATT_OFF) begin
                     att_d[key_q] = 1'b0;
                  end
                  if (NOTE_END) begin
                     active_d[key_q] = 1'b0;
                  end
               end
            end
         end
         ST_DONE: begin
            sample_out_d   = TONE[31:8];
            sample_valid_d = 1'b1;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Applied last so a write to the key under scan wins over its scan-driven clears.
      if (LD_VEL) begin
         if (AVL_VEL != 7'd0) begin
            held_d[AVL_KEY]    = 1'b1;
            att_d[AVL_KEY]     = 1'b1;
            active_d[AVL_KEY]  = 1'b1;
            restart_d[AVL_KEY] = 1'b1;
         end else begin
            held_d[AVL_KEY] = 1'b0;
            att_d[AVL_KEY]  = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q        <= ST_IDLE;
         key_q          <= 7'd0;
         held_q         <= '0;
         att_q          <= '0;
         active_q       <= '0;
         restart_q      <= '0;
         sample_out_q   <= 24'd0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_q          <= key_d;
         held_q         <= held_d;
         att_q          <= att_d;
         active_q       <= active_d;
         restart_q      <= restart_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_synth_voice_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_synth_voice_sequencer: scoreboard bench with a per-key behavioural model. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_synth_voice_sequencer;

   localparam int NK = 128;

   logic        CLK = 1'b0;
   logic        RESET, SAMPLE_REQ, LD_VEL, NOTE_END, ATT_OFF;
   logic [6:0]  AVL_KEY, AVL_VEL;
   logic [31:0] TONE;
   logic [6:0]  KEY;
   logic        LD_PHASE, LD_AMP, LD_TONE, PHASE_MUX, TONE_MUX, AMP_SEL;
   logic        NOTE_ON, ATT_ON, SAMPLE_VALID, BUSY, OVERRUN;
   logic [23:0] SAMPLE_OUT;

   synth_voice_sequencer #(.NUM_KEYS(NK)) dut (
      .CLK(CLK), .RESET(RESET), .SAMPLE_REQ(SAMPLE_REQ), .LD_VEL(LD_VEL),
      .AVL_KEY(AVL_KEY), .AVL_VEL(AVL_VEL), .NOTE_END(NOTE_END), .ATT_OFF(ATT_OFF),
      .TONE(TONE), .KEY(KEY), .LD_PHASE(LD_PHASE), .LD_AMP(LD_AMP), .LD_TONE(LD_TONE),
      .PHASE_MUX(PHASE_MUX), .TONE_MUX(TONE_MUX), .AMP_SEL(AMP_SEL),
      .NOTE_ON(NOTE_ON), .ATT_ON(ATT_ON), .SAMPLE_OUT(SAMPLE_OUT),
      .SAMPLE_VALID(SAMPLE_VALID), .BUSY(BUSY), .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [6:0] key;
      logic       key_chk;
      logic       ld_p, ld_a, ld_t, pm, tm, asel, non, aon, ovr;
   } cyc_t;

   cyc_t        exp_cyc[$];
   logic [23:0] exp_smp[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;
   bit          m_overrun;
   logic [23:0] m_last;

   // Model of each key: pressed (finger down), attack phase, sounding, freshly struck.
   bit pressed[NK], attack[NK], sounding[NK], fresh[NK];

   // Per-scan plan of data_path returns and side events.
   bit plan_ne[NK], plan_ao[NK];
   int plan_vel_at, plan_vkey, plan_vvel, plan_req_at, plan_rst_at;

   task automatic clear_plan();
      for (int k = 0; k < NK; k++) begin
         plan_ne[k] = 1'b0;
         plan_ao[k] = 1'b0;
      end
      plan_vel_at = -1; plan_vkey = 0; plan_vvel = 0;
      plan_req_at = -1; plan_rst_at = -1;
   endtask

   task automatic model_vel(input int key, input int vel);
      if (vel != 0) begin
         pressed[key] = 1'b1; attack[key] = 1'b1; sounding[key] = 1'b1; fresh[key] = 1'b1;
      end else begin
         pressed[key] = 1'b0; attack[key] = 1'b0;
      end
   endtask

   task automatic idle_inputs();
      SAMPLE_REQ = 1'b0; LD_VEL = 1'b0; AVL_KEY = 7'd0; AVL_VEL = 7'd0;
      NOTE_END = 1'b0; ATT_OFF = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RESET = 1'b1;
      exp_cyc.delete();
      exp_smp.delete();
      m_overrun = 1'b0;
      m_last    = 24'd0;
      for (int k = 0; k < NK; k++) begin
         pressed[k] = 1'b0; attack[k] = 1'b0; sounding[k] = 1'b0; fresh[k] = 1'b0;
      end
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      checks++;
      if (KEY !== 7'd0 || BUSY !== 1'b0 || SAMPLE_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got key=%0d busy=%b valid=%b ovr=%b, expected 0 0 0 0",
                  KEY, BUSY, SAMPLE_VALID, OVERRUN);
      end
   endtask

   task automatic vel_write(input int key, input int vel);
      LD_VEL = 1'b1; AVL_KEY = 7'(key); AVL_VEL = 7'(vel);
      model_vel(key, vel);
      @(negedge CLK);
      LD_VEL = 1'b0;
   endtask

   // Called on a negedge while the DUT is idle; returns on the negedge of the valid cycle.
   task automatic scan(input logic [31:0] tone);
      cyc_t r;
      bit   ovr_k;
      r = '0; r.key_chk = 1'b1; r.ld_t = 1'b1; r.ovr = m_overrun;
      exp_cyc.push_back(r);
      for (int k = 0; k < NK; k++) begin
         ovr_k = m_overrun | (plan_req_at >= 0 && k > plan_req_at);
         r = '0; r.key = 7'(k); r.key_chk = 1'b1; r.ovr = ovr_k;
         if (sounding[k]) begin
            r.ld_p = 1'b1; r.ld_a = 1'b1; r.ld_t = 1'b1; r.tm = 1'b1;
            r.pm   = ~fresh[k];
            r.asel = fresh[k];
            r.aon  = fresh[k] | attack[k];
            r.non  = pressed[k];
            if (fresh[k]) begin
               fresh[k] = 1'b0;
            end else begin
               if (plan_ao[k]) attack[k] = 1'b0;
               if (plan_ne[k]) sounding[k] = 1'b0;
            end
         end
         exp_cyc.push_back(r);
         if (plan_vel_at == k) model_vel(plan_vkey, plan_vvel);
      end
      r = '0; r.ovr = m_overrun | (plan_req_at >= 0);
      exp_cyc.push_back(r);
      exp_smp.push_back(tone[31:8]);
      if (plan_req_at >= 0) m_overrun = 1'b1;

      SAMPLE_REQ = 1'b1; TONE = tone;
      @(negedge CLK);
      SAMPLE_REQ = 1'b0;
      for (int k = 0; k < NK; k++) begin
         @(negedge CLK);
         if (plan_rst_at == k) begin
            do_reset();
            return;
         end
         NOTE_END   = plan_ne[k];
         ATT_OFF    = plan_ao[k];
         SAMPLE_REQ = (plan_req_at == k);
         LD_VEL     = (plan_vel_at == k);
         AVL_KEY    = 7'(plan_vkey);
         AVL_VEL    = 7'(plan_vvel);
      end
      @(negedge CLK);
      idle_inputs();
      @(negedge CLK);
   endtask

   // Monitor: pops one expected record per busy cycle, one sample per valid pulse.
   initial begin
      cyc_t e, a;
      forever begin
         @(posedge CLK);
         #1;
         if (mon_en) begin
            checks++;
            if (BUSY === 1'b1) begin
               if (exp_cyc.size() == 0) begin
                  errors++;
                  $display("FAIL busy_unexpected: got BUSY=1 key=%0d, expected idle", KEY);
               end else begin
                  e = exp_cyc.pop_front();
                  a = e;
                  if (e.key_chk) a.key = KEY;
                  a.ld_p = LD_PHASE; a.ld_a = LD_AMP; a.ld_t = LD_TONE; a.pm = PHASE_MUX;
                  a.tm = TONE_MUX; a.asel = AMP_SEL; a.non = NOTE_ON; a.aon = ATT_ON;
                  a.ovr = OVERRUN;
                  if (a !== e || SAMPLE_VALID !== 1'b0) begin
                     errors++;
                     $display("FAIL scan_cycle: got %h valid=%b, expected %h valid=0 (key,chk,ldp,lda,ldt,pm,tm,as,non,aon,ovr)",
                              a, SAMPLE_VALID, e);
                  end
               end
            end else begin
               if (SAMPLE_VALID === 1'b1) begin
                  if (exp_smp.size() == 0) begin
                     errors++;
                     $display("FAIL valid_unexpected: got SAMPLE_VALID=1 out=%h, expected none", SAMPLE_OUT);
                  end else begin
                     m_last = exp_smp.pop_front();
                  end
               end
               if ({LD_PHASE, LD_AMP, LD_TONE, PHASE_MUX, TONE_MUX, AMP_SEL, NOTE_ON, ATT_ON} !== 8'd0 ||
                   BUSY !== 1'b0 || OVERRUN !== m_overrun || SAMPLE_OUT !== m_last) begin
                  errors++;
                  $display("FAIL idle_state: got strobes=%b busy=%b ovr=%b out=%h, expected 0 0 %b %h",
                           {LD_PHASE, LD_AMP, LD_TONE, PHASE_MUX, TONE_MUX, AMP_SEL, NOTE_ON, ATT_ON},
                           BUSY, OVERRUN, SAMPLE_OUT, m_overrun, m_last);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nev, key;
      idle_inputs();
      RESET = 1'b1;
      TONE  = 32'd0;
      clear_plan();
      @(negedge CLK);
      do_reset();
      mon_en = 1'b1;
      repeat (3) @(negedge CLK);

      // Empty keyboard: only the clear strobe, zero sample.
      scan(32'd0);

      // Note-on key 60: restart pattern, then the running pattern.
      vel_write(60, 100);
      scan(32'h0000_1200);
      scan(32'h0001_3400);

      // Attack ends during key 60.
      plan_ao[60] = 1'b1;
      scan(32'hFFFF_0000);
      clear_plan();
      scan(32'h0000_0100);

      // Release then note end.
      vel_write(60, 0);
      scan(32'h7FFF_FF00);
      plan_ne[60] = 1'b1;
      scan(32'h8000_0000);
      clear_plan();
      scan(32'h0000_0000);

      // Request arriving mid-scan (cycle 50 = key 48).
      vel_write(5, 33);
      plan_req_at = 48;
      scan(32'h0ABC_DE00);
      clear_plan();
      repeat (4) @(negedge CLK);

      // Note-on for key 60 in the same cycle as its note end.
      vel_write(60, 100);
      scan(32'h0000_0000);
      plan_ne[60] = 1'b1;
      plan_vel_at = 60; plan_vkey = 60; plan_vvel = 100;
      scan(32'h0000_0000);
      clear_plan();
      scan(32'h1234_5678);

      // Reset in the middle of a scan.
      vel_write(10, 1);
      vel_write(100, 127);
      plan_rst_at = 70;
      scan(32'h5555_5555);
      clear_plan();
      repeat (2) @(negedge CLK);
      scan(32'h0000_0A00);

      // Randomized scans.
      for (int t = 0; t < 30; t++) begin
         nev = $urandom_range(0, 4);
         for (int i = 0; i < nev; i++) begin
            key = (($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, NK - 1));
            vel_write(key, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 127));
         end
         clear_plan();
         for (int k = 0; k < NK; k++) begin
            plan_ne[k] = ($urandom_range(0, 7) == 0);
            plan_ao[k] = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 1) == 1) begin
            plan_vel_at = $urandom_range(0, 15);
            plan_vkey   = ($urandom_range(0, 1) == 1) ? plan_vel_at : $urandom_range(0, 15);
            plan_vvel   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 127);
         end
         if ($urandom_range(0, 9) == 0) plan_req_at = $urandom_range(0, NK - 1);
         scan($urandom);
         clear_plan();
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      repeat (5) @(negedge CLK);
      checks++;
      if (exp_cyc.size() != 0 || exp_smp.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations: got %0d cycles %0d samples pending, expected 0 0",
                  exp_cyc.size(), exp_smp.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/synth_voice_sequencer.md
# synth_voice_sequencer

Per-sample control sequencer that sits directly upstream of the synth `data_path`. On each codec sample request it clears the tone accumulator and walks every key once. For each active key it drives the `data_path` load strobes and mux selects. It tracks the per-key note/attack/active state from Avalon velocity writes and the `data_path` status returns, then hands the finished mixed sample to the audio output stage.

## Interface
- `NUM_KEYS`, 128: keys scanned per sample; key index width is 7 bits.
- `CLK` in 1: system clock; all logic on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `SAMPLE_REQ` in 1: one-cycle pulse from the codec side, one per audio sample period.
- `LD_VEL` in 1: Avalon velocity write strobe, the same signal that feeds `data_path`.
- `AVL_KEY` in 7: key being written.
- `AVL_VEL` in 7: velocity written; non-zero means note-on, zero means note-off.
- `NOTE_END` in 1: from `data_path`, valid for the current `KEY`.
- `ATT_OFF` in 1: from `data_path`, valid for the current `KEY`.
- `TONE` in 32: accumulated signed tone from `data_path`.
- `KEY` out 7: key index presented to `data_path`.
- `LD_PHASE`, `LD_AMP`, `LD_TONE` out 1 each: `data_path` load strobes.
- `PHASE_MUX`, `TONE_MUX`, `AMP_SEL` out 1 each: `data_path` selects.
- `NOTE_ON`, `ATT_ON` out 1 each: per-key envelope controls for the current `KEY`.
- `SAMPLE_OUT` out 24: signed mixed sample, equal to `TONE[31:8]`.
- `SAMPLE_VALID` out 1: one-cycle pulse when `SAMPLE_OUT` updates.
- `BUSY` out 1: high in every state except IDLE.
- `OVERRUN` out 1: sticky flag; set when a `SAMPLE_REQ` arrives while BUSY.

## Operation
- Per-key state bits, each `NUM_KEYS` wide: `held`, `att`, `active`, `restart`.
- Velocity events, applied on the clock edge where `LD_VEL` is high:
  - Non-zero `AVL_VEL`: sets `held`, `att`, `active` and `restart` for `AVL_KEY`.
  - Zero `AVL_VEL`: clears `held` and `att` for `AVL_KEY`; the key releases.
- FSM states:
  - IDLE: `SAMPLE_REQ` moves the FSM to CLEAR.
  - CLEAR: `KEY`=0, `LD_TONE`=1, `TONE_MUX`=0, so TONE is zeroed. Moves to SCAN.
  - SCAN: one cycle per key; `KEY` increments each cycle. After key `NUM_KEYS-1` it moves to DONE.
  - DONE: registers `SAMPLE_OUT` and pulses `SAMPLE_VALID`, then returns to IDLE.
- SCAN cycle, inactive key: all `LD_*` = 0 and the key's state is unchanged.
- SCAN cycle, active key with `restart`=1:
  - Outputs: `LD_PHASE`=`LD_AMP`=`LD_TONE`=1, `PHASE_MUX`=0, `AMP_SEL`=1, `TONE_MUX`=1, `ATT_ON`=1, `NOTE_ON`=`held`.
  - Effect: phase and amplitude are zeroed, so this pass adds nothing to TONE.
  - Clears `restart`; `NOTE_END` and `ATT_OFF` are ignored.
- SCAN cycle, active key with `restart`=0:
  - Outputs: `LD_PHASE`=`LD_AMP`=`LD_TONE`=1, `PHASE_MUX`=1, `AMP_SEL`=0, `TONE_MUX`=1, `ATT_ON`=`att`, `NOTE_ON`=`held`.
  - At the clock edge: `ATT_OFF` clears `att`; `NOTE_END` clears `active`.
- Strobes and selects are decoded combinationally from the registered state, the registered `KEY` and the registered per-key bits. They are therefore stable for the whole cycle.
- In IDLE, CLEAR and DONE, every strobe is 0 except the CLEAR `LD_TONE`. `ATT_ON`, `NOTE_ON`, `PHASE_MUX` and `AMP_SEL` are 0 in those states.
- Simultaneous events:
  - A velocity event on the key currently being scanned overrides any scan-driven clear of that key's bits in the same cycle.
  - A velocity event on any other key applies normally.
  - Note-on while a key is releasing re-arms it with `restart`=1.
- `SAMPLE_REQ` while BUSY: the request is dropped, `OVERRUN` is set, and the scan in progress continues unaffected.
- Reset, including mid-scan:
  - FSM returns to IDLE, `KEY`=0, all per-key bits cleared.
  - `SAMPLE_OUT`=0, `SAMPLE_VALID`=0, `OVERRUN`=0, `BUSY`=0, all strobes and selects 0.

## Timing
- Let `SAMPLE_REQ` be sampled high in IDLE at edge 0.
  - Cycle 1: CLEAR.
  - Cycles 2..129: SCAN of keys 0..127.
  - Cycle 130: DONE. TONE holds the complete sum during this cycle.
  - Cycle 131: `SAMPLE_OUT` updated, `SAMPLE_VALID`=1, FSM back in IDLE.
- Request-to-valid latency is 131 cycles.
- The next `SAMPLE_REQ` is accepted from cycle 131 onward. A request sampled in cycles 1..130 sets `OVERRUN` at the following edge.
- A velocity event takes effect on the key's next SCAN cycle that starts after the write edge.
- The sample period must be at least 131 cycles.

## Test plan
- Reset, then `SAMPLE_REQ` with no notes -> `LD_TONE` high only in cycle 1, no `LD_PHASE`/`LD_AMP` in cycles 2..129, `SAMPLE_VALID` at cycle 131, `SAMPLE_OUT`=0.
- `LD_VEL` key 60, vel 100, then a request -> at cycle 62: `PHASE_MUX`=0, `AMP_SEL`=1, `ATT_ON`=1, `NOTE_ON`=1. Next request, cycle 62: `PHASE_MUX`=1, `AMP_SEL`=0.
- `ATT_OFF`=1 driven during key 60's cycle -> `ATT_ON`=0 for key 60 on all later scans.
- Note-off key 60, then `NOTE_END`=1 at key 60 -> `NOTE_ON`=0 and `ATT_ON`=0 from the next scan; the scan after `NOTE_END` shows no strobes at cycle 62.
- `SAMPLE_REQ` at cycle 50 of a scan -> `OVERRUN`=1 and stays 1; the scan ends normally with exactly one `SAMPLE_VALID`; no second scan starts.
- Note-on key 60 in the same cycle as key 60's scan with `NOTE_END`=1 -> key stays active; the next scan shows the restart pattern. `TONE` driven to 0x12345678 in DONE -> `SAMPLE_OUT`=0x123456.
